// File: rtl/serial_bit_receiver.sv
// Serial byte receiver: recovers start/data/stop framed LSB-first bytes from an asynchronous line
// and drives a SIPO with one Serial_Data/Shift_Flag pair per data bit, then flags completion or error.
module serial_bit_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CLOCK_50,
    input  logic Reset_n,
    input  logic Serial_In,
    output logic Serial_Data,
    output logic Shift_Flag,
    output logic Byte_Valid,
    output logic Frame_Error,
    output logic Busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO = '0;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]       bit_idx_q, bit_idx_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                serial_data_q, serial_data_d;
    logic                shift_flag_q, shift_flag_d;
    logic                byte_valid_q, byte_valid_d;
    logic                frame_error_q, frame_error_d;
    logic                rx;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Serial_In};
        end
    end

    assign rx = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= CNT_ZERO;
            bit_idx_q     <= IDX_ZERO;
            serial_data_q <= 1'b1;
            shift_flag_q  <= 1'b0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            serial_data_q <= serial_data_d;
            shift_flag_q  <= shift_flag_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        bit_idx_d     = bit_idx_q;
        serial_data_d = serial_data_q;
        shift_flag_d  = 1'b0;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = CNT_ZERO;
                if (!rx) begin
                    state_d   = S_START;
                    bit_idx_d = IDX_ZERO;
                end
            end

            // Re-check the line at mid start bit; a high level here is a glitch.
            S_START: begin
                if (bit_cnt_q == CNT_MID) begin
                    bit_cnt_d = CNT_ZERO;
                    if (!rx) begin
                        state_d   = S_DATA;
                        bit_idx_d = IDX_ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d     = CNT_ZERO;
                    serial_data_d = rx;
                    shift_flag_d  = 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d   = S_STOP;
                        bit_idx_d = IDX_ZERO;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = CNT_ZERO;
                    if (rx) begin
                        byte_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            // A line held low after a bad stop bit must return high before a new frame is accepted.
            S_BREAK: begin
                bit_cnt_d = CNT_ZERO;
                if (rx) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = CNT_ZERO;
                bit_idx_d = IDX_ZERO;
            end
        endcase
    end

    assign Serial_Data = serial_data_q;
    assign Shift_Flag  = shift_flag_q;
    assign Byte_Valid  = byte_valid_q;
    assign Frame_Error = frame_error_q;
    assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_bit_receiver.sv
// Bench for serial_bit_receiver: drives whole serial frames cycle by cycle, logs every output pulse,
// and checks each frame against expectations derived from the frame contents and bit timing.
module tb_serial_bit_receiver;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int SS  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_in = 1'b1;
    logic serial_data, shift_flag, byte_valid, frame_error, busy;

    serial_bit_receiver #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .CLOCK_50   (clk),
        .Reset_n    (rst_n),
        .Serial_In  (serial_in),
        .Serial_Data(serial_data),
        .Shift_Flag (shift_flag),
        .Byte_Valid (byte_valid),
        .Frame_Error(frame_error),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    int         sf_cyc[$];
    logic       sf_dat[$];
    int         bv_cyc[$];
    logic [7:0] bv_byte[$];
    int         fe_cyc[$];
    logic [7:0] sipo = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive the line, sample outputs 1 time unit after the edge, log pulses.
    task automatic step(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
        cycle++;
        if (shift_flag) begin
            sf_cyc.push_back(cycle);
            sf_dat.push_back(serial_data);
            sipo = {serial_data, sipo[7:1]};
        end
        if (byte_valid) begin
            bv_cyc.push_back(cycle);
            bv_byte.push_back(sipo);
        end
        if (frame_error) fe_cyc.push_back(cycle);
        if (shift_flag || byte_valid || frame_error)
            chk("pulse_exclusive", int'(shift_flag) + int'(byte_valid) + int'(frame_error), 1);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic clear_log();
        sf_cyc.delete();
        sf_dat.delete();
        bv_cyc.delete();
        bv_byte.delete();
        fe_cyc.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < DB; i++) hold(d[i], CPB);
        hold(stop, CPB);
    endtask

    // Expected: start seen SS+1 cycles late, sampled half a bit in, then one bit period per data bit.
    task automatic check_frame(input string tag, input int t0, input logic [7:0] d, input logic stop_ok);
        int n;
        n = sf_cyc.size();
        chk({tag, "_nshift"}, n, DB);
        for (int i = 0; i < n && i < DB; i++) begin
            chk({tag, "_bit"}, sf_dat[i], d[i]);
            if (i == 0) chk({tag, "_first_shift_time"}, sf_cyc[0], t0 + SS + CPB / 2 + CPB);
            else        chk({tag, "_shift_spacing"}, sf_cyc[i] - sf_cyc[i-1], CPB);
        end
        if (stop_ok) begin
            chk({tag, "_nvalid"}, bv_cyc.size(), 1);
            chk({tag, "_nferr"}, fe_cyc.size(), 0);
            if (bv_cyc.size() > 0 && n > 0) begin
                chk({tag, "_valid_gap"}, bv_cyc[0] - sf_cyc[n-1], CPB);
                chk({tag, "_parallel"}, bv_byte[0], d);
            end
        end else begin
            chk({tag, "_nferr"}, fe_cyc.size(), 1);
            chk({tag, "_nvalid"}, bv_cyc.size(), 0);
            if (fe_cyc.size() > 0 && n > 0)
                chk({tag, "_ferr_gap"}, fe_cyc[0] - sf_cyc[n-1], CPB);
        end
        $display("frame %s data=0x%02h stop=%0b shifts=%0d valid=%0d ferr=%0d",
                 tag, d, stop_ok, n, bv_cyc.size(), fe_cyc.size());
        clear_log();
    endtask

    initial begin
        int t0;
        logic [7:0] d;
        logic ok;
        int gap;
        bit aborted;

        // Reset state
        hold(1'b1, 3);
        chk("reset_serial_data", serial_data, 1);
        chk("reset_shift_flag", shift_flag, 0);
        chk("reset_byte_valid", byte_valid, 0);
        chk("reset_frame_error", frame_error, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        hold(1'b1, 5);
        clear_log();

        // Frame 0xA5
        t0 = cycle + 1;
        send_frame(8'hA5, 1'b1);
        check_frame("a5", t0, 8'hA5, 1'b1);
        hold(1'b1, 4);

        // Short glitch: rejected at mid start bit
        step(1'b0);
        step(1'b0);
        chk("glitch_busy_before_latency", busy, 0);
        step(1'b0);
        chk("glitch_busy_after_latency", busy, 1);
        step(1'b0);
        hold(1'b1, 8);
        chk("glitch_busy_cleared", busy, 0);
        hold(1'b1, 30);
        chk("glitch_nshift", sf_cyc.size(), 0);
        chk("glitch_nvalid", bv_cyc.size(), 0);
        chk("glitch_nferr", fe_cyc.size(), 0);
        $display("frame glitch shifts=%0d valid=%0d ferr=%0d", sf_cyc.size(), bv_cyc.size(), fe_cyc.size());
        clear_log();

        // Line held low for 200 cycles: break condition
        t0 = cycle + 1;
        hold(1'b0, 200);
        step(1'b1);
        step(1'b1);
        chk("break_busy_held", busy, 1);
        step(1'b1);
        chk("break_busy_released", busy, 0);
        hold(1'b1, 10);
        check_frame("break", t0, 8'h00, 1'b0);

        // Back-to-back 0x00 then 0xFF
        t0 = cycle + 1;
        send_frame(8'h00, 1'b1);
        check_frame("b2b_00", t0, 8'h00, 1'b1);
        t0 = cycle + 1;
        send_frame(8'hFF, 1'b1);
        check_frame("b2b_ff", t0, 8'hFF, 1'b1);
        hold(1'b1, 4);

        // Reset after the 3rd Shift_Flag of 0x5A
        d = 8'h5A;
        aborted = 1'b0;
        hold(1'b0, CPB);
        for (int i = 0; i < DB && !aborted; i++) begin
            for (int k = 0; k < CPB && !aborted; k++) begin
                step(d[i]);
                if (sf_cyc.size() == 3) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_mid_serial_data", serial_data, 1);
                    chk("rst_mid_shift_flag", shift_flag, 0);
                    chk("rst_mid_byte_valid", byte_valid, 0);
                    chk("rst_mid_frame_error", frame_error, 0);
                    chk("rst_mid_busy", busy, 0);
                    aborted = 1'b1;
                end
            end
        end
        chk("rst_mid_reached", aborted, 1);
        clear_log();
        hold(1'b1, 2);
        rst_n = 1'b1;
        hold(1'b1, 3 * CPB);
        chk("rst_mid_no_shift", sf_cyc.size(), 0);
        chk("rst_mid_no_valid", bv_cyc.size(), 0);
        chk("rst_mid_no_ferr", fe_cyc.size(), 0);
        $display("frame reset_abort data=0x5a shifts_after_reset=%0d", sf_cyc.size());
        clear_log();
        t0 = cycle + 1;
        send_frame(8'h3C, 1'b1);
        check_frame("after_reset_3c", t0, 8'h3C, 1'b1);
        hold(1'b1, 4);

        // Randomised frames, some with a bad stop bit, random inter-frame gaps
        for (int f = 0; f < 12; f++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
            t0  = cycle + 1;
            send_frame(d, ok);
            check_frame("random", t0, d, ok);
            hold(1'b1, gap);
        end
        hold(1'b1, CPB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
